score_display_ctrl: RTL

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/score_display_ctrl.sv
// Binary-to-BCD display controller: serial double-dabble conversion into a
// five-digit BCD register, with leading-zero blanking and a free-running blink.
module score_display_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] val,
  input  logic        val_valid,
  output logic        val_ready,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [19:0] digits,
  output logic [4:0]  digit_on,
  output logic        done
);

  localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_step;
  logic   w_load;

  logic [15:0]   r_shift;
  logic [19:0]   r_scratch;
  logic [3:0]    r_cnt;
  logic          r_blz;
  logic [19:0]   w_adj;
  logic [19:0]   r_digits;
  logic [4:0]    r_mask;
  logic          r_done;
  logic [PW-1:0] r_presc;
  logic          r_phase;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [19:0] dabble_adjust(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 5; i++) begin
      if (s[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = s[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // A digit stays lit once it or any higher digit is non-zero; ones always lit.
  function automatic logic [4:0] lz_mask(input logic [19:0] d, input logic blz);
    logic [4:0] m;
    logic       seen;
    m    = 5'b11111;
    seen = 1'b0;
    if (blz) begin
      for (int i = 4; i >= 1; i--) begin
        seen = seen | (d[i*4 +: 4] != 4'd0);
        m[i] = seen;
      end
      m[0] = 1'b1;
    end else begin
      m = 5'b11111;
    end
    return m;
  endfunction

  assign w_adj = dabble_adjust(r_scratch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (val_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: begin
        w_step = 1'b1;
        if (r_cnt == 4'd15) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= 16'd0;
      r_scratch <= 20'd0;
      r_cnt     <= 4'd0;
      r_blz     <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= val;
      r_scratch <= 20'd0;
      r_cnt     <= 4'd0;
      r_blz     <= blank_lz;
    end else if (w_step) begin
      // The cast drops the top bit of the adjusted scratch, which is always 0.
      r_scratch <= 20'({w_adj, r_shift[15]});
      r_shift   <= {r_shift[14:0], 1'b0};
      r_cnt     <= r_cnt + 4'd1;
    end else begin
      r_shift   <= r_shift;
      r_scratch <= r_scratch;
      r_cnt     <= r_cnt;
      r_blz     <= r_blz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= 20'd0;
      r_mask   <= 5'b11111;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_digits <= r_scratch;
        r_mask   <= lz_mask(r_scratch, r_blz);
      end else begin
        r_digits <= r_digits;
        r_mask   <= r_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_phase <= 1'b0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_phase <= r_phase;
    end
  end

  assign val_ready = (r_state == S_IDLE);
  assign digits    = r_digits;
  assign done      = r_done;
  assign digit_on  = r_mask & ~{5{blink_en & r_phase}};

endmodule
